twiddle64_sched: RTL and testbench

// - Sequences the 64-point radix-8 (8x8) inter-stage twiddle multiply. Counts samples in a frame and computes k = n1*n2.
// - Folds each W64^k onto one of the 9 first-octant constants (0..8) plus swap/negate flags.
// - Presents each sample with its constant select and flags, cycle-aligned, to the constant-multiplier bank.
// - Sits between the first radix-8 butterfly and the twiddle constant multipliers. Valid/ready stream with backpressure.

---
 rtl/twiddle64_pkg.sv | 37 +++
 rtl/twiddle64_sched_if.sv | 43 ++++
 rtl/twiddle64_fold.sv | 20 ++
 rtl/twiddle64_sched.sv | 111 +++++++++++
 tb/tb_twiddle64_sched.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/twiddle64_pkg.sv
// twiddle64_pkg
// Shared constants, the twiddle flag bundle and the first-octant fold
// helper used by the 64-point radix-8 twiddle scheduler.
//   TW_SEL_W  width of the constant select
//   TW_NUM    number of first-octant constants (angles 0..8 * 2*pi/64)
//   FFT_LOG2  log2 of the transform length (width of n and k)
package twiddle64_pkg;

    localparam int TW_SEL_W = 4;
    localparam int TW_NUM   = 9;
    localparam int FFT_LOG2 = 6;

    typedef struct packed {
        logic [TW_SEL_W-1:0] sel;
        logic                swap;
        logic                neg_re;
        logic                neg_im;
    } tw_t;

    // Forward-transform fold of W64^k. The octant o = k[5:3] picks the
    // mirror (odd octants count down from 8), the cos/sin swap and the
    // sign pattern; r = k[2:0] is the offset inside the octant.
    function automatic tw_t tw_fold(input logic [FFT_LOG2-1:0] k);
        localparam logic [TW_SEL_W-1:0] SEL_MAX = TW_SEL_W'(TW_NUM - 1);
        logic [2:0] o;
        logic [2:0] r;
        tw_t        t;
        o        = k[5:3];
        r        = k[2:0];
        t.sel    = o[0] ? (SEL_MAX - {1'b0, r}) : {1'b0, r};
        t.swap   = o[0] ^ o[1];
        t.neg_re = o[1] ^ o[2];
        t.neg_im = ~o[2];
        return t;
    endfunction

endpackage

// File: rtl/twiddle64_sched_if.sv
// twiddle64_sched_if
// Stream bundle of the twiddle scheduler: the sample input stream from the
// first butterfly and the aligned sample + twiddle-select output stream.
//   slave  : the scheduler (consumes din_*, produces dout_*/tw_*/sync_err)
//   master : the environment around it (drives din_*, dout_ready)
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; valid never waits on ready, and the producer holds a presented beat
// unchanged until it transfers.
interface twiddle64_sched_if
    import twiddle64_pkg::*;
#(
    parameter int DATA_WIDTH = 14
);
    logic                  din_valid;
    logic                  din_ready;
    logic                  din_sof;
    logic                  din_inverse;
    logic [DATA_WIDTH-1:0] din_real;
    logic [DATA_WIDTH-1:0] din_imag;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [DATA_WIDTH-1:0] dout_real;
    logic [DATA_WIDTH-1:0] dout_imag;
    logic                  dout_sof;
    logic                  dout_last;
    logic [TW_SEL_W-1:0]   tw_sel;
    logic                  tw_swap;
    logic                  tw_neg_re;
    logic                  tw_neg_im;
    logic                  sync_err;

    modport slave (
        input  din_valid, din_sof, din_inverse, din_real, din_imag, dout_ready,
        output din_ready, dout_valid, dout_real, dout_imag, dout_sof, dout_last,
               tw_sel, tw_swap, tw_neg_re, tw_neg_im, sync_err
    );

    modport master (
        output din_valid, din_sof, din_inverse, din_real, din_imag, dout_ready,
        input  din_ready, dout_valid, dout_real, dout_imag, dout_sof, dout_last,
               tw_sel, tw_swap, tw_neg_re, tw_neg_im, sync_err
    );
endinterface

// File: rtl/twiddle64_fold.sv
// twiddle64_fold
// Combinational octant fold feeding the S2 register of the scheduler.
//   k       in   product n1*n2 (0..49)
//   inverse in   1: conjugate twiddles (flip the imag sign)
//   tw      out  constant select and swap/negate flags
module twiddle64_fold
    import twiddle64_pkg::*;
(
    input  logic [FFT_LOG2-1:0] k,
    input  logic                inverse,
    output tw_t                 tw
);
    tw_t fwd;

    always_comb begin
        fwd       = tw_fold(k);
        tw        = fwd;
        tw.neg_im = fwd.neg_im ^ inverse;
    end
endmodule

// File: rtl/twiddle64_sched.sv
// twiddle64_sched
// Sequences the inter-stage twiddle multiply of a 64-point 8x8 FFT. Counts
// samples in a frame, forms k = n[5:3]*n[2:0], folds W64^k onto one of nine
// first-octant constants plus swap/negate flags and presents them aligned
// with the sample to the constant-multiplier bank.
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of twiddle64_sched_if (din_* in, dout_*/tw_*/sync_err out)
// Two register stages S1 -> S2 share one enable adv = ~s2_valid | dout_ready,
// which is also din_ready; a stall freezes both stages and every output.
module twiddle64_sched
    import twiddle64_pkg::*;
#(
    parameter int DATA_WIDTH = 14
)(
    input  logic                    clk,
    input  logic                    rst_n,
    twiddle64_sched_if.slave        bus
);
    logic                  adv;
    logic                  accept;
    logic [FFT_LOG2-1:0]   cnt;
    logic [FFT_LOG2-1:0]   n_cur;
    logic                  inv_frame;
    logic                  inv_cur;
    logic                  sync_err_q;

    logic                  s1_valid;
    logic [FFT_LOG2-1:0]   s1_k;
    logic [DATA_WIDTH-1:0] s1_real;
    logic [DATA_WIDTH-1:0] s1_imag;
    logic                  s1_sof;
    logic                  s1_last;
    logic                  s1_inv;
    tw_t                   s1_tw;

    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_real;
    logic [DATA_WIDTH-1:0] s2_imag;
    logic                  s2_sof;
    logic                  s2_last;
    tw_t                   s2_tw;

    assign adv           = ~s2_valid | bus.dout_ready;
    assign bus.din_ready = adv;
    assign accept        = bus.din_valid & adv;

    // A start-of-frame sample always takes index 0, whatever the counter says.
    assign n_cur   = bus.din_sof ? '0 : cnt;
    // The inverse flag is captured at index 0 and ignored for the rest of the frame.
    assign inv_cur = (n_cur == '0) ? bus.din_inverse : inv_frame;

    twiddle64_fold u_fold (
        .k       (s1_k),
        .inverse (s1_inv),
        .tw      (s1_tw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            inv_frame  <= 1'b0;
            sync_err_q <= 1'b0;
            s1_valid   <= 1'b0;
            s1_k       <= '0;
            s1_real    <= '0;
            s1_imag    <= '0;
            s1_sof     <= 1'b0;
            s1_last    <= 1'b0;
            s1_inv     <= 1'b0;
            s2_valid   <= 1'b0;
            s2_real    <= '0;
            s2_imag    <= '0;
            s2_sof     <= 1'b0;
            s2_last    <= 1'b0;
            s2_tw      <= '0;
        end else begin
            sync_err_q <= accept & bus.din_sof & (cnt != '0);
            if (accept) begin
                cnt       <= n_cur + 6'd1;
                inv_frame <= inv_cur;
            end
            if (adv) begin
                s1_valid <= bus.din_valid;
                s1_k     <= {3'b000, n_cur[5:3]} * {3'b000, n_cur[2:0]};
                s1_real  <= bus.din_real;
                s1_imag  <= bus.din_imag;
                s1_sof   <= bus.din_sof;
                s1_last  <= (n_cur == 6'd63);
                s1_inv   <= inv_cur;
                s2_valid <= s1_valid;
                s2_real  <= s1_real;
                s2_imag  <= s1_imag;
                s2_sof   <= s1_sof;
                s2_last  <= s1_last;
                s2_tw    <= s1_tw;
            end
        end
    end

    assign bus.dout_valid = s2_valid;
    assign bus.dout_real  = s2_real;
    assign bus.dout_imag  = s2_imag;
    assign bus.dout_sof   = s2_sof;
    assign bus.dout_last  = s2_last;
    assign bus.tw_sel     = s2_tw.sel;
    assign bus.tw_swap    = s2_tw.swap;
    assign bus.tw_neg_re  = s2_tw.neg_re;
    assign bus.tw_neg_im  = s2_tw.neg_im;
    assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_twiddle64_sched.sv
// tb_twiddle64_sched
// Drives frames through twiddle64_sched, pushes the expected sample record
// for every accepted input and checks each emitted output against it,
// including the twiddle value implied by the select/flags.
module tb_twiddle64_sched;
    import twiddle64_pkg::*;

    localparam int DW = 14;
    // record: {real, imag, sof, last, n[5:0], inverse}
    localparam int W  = 2 * DW + 2 + 6 + 1;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    twiddle64_sched_if #(.DATA_WIDTH(DW)) bus ();

    twiddle64_sched #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q[$];
    logic [5:0]     n_model = '0;
    logic           inv_model = 1'b0;
    bit             sync_arm = 1'b0;
    bit             sync_due = 1'b0;
    bit             rand_ready = 1'b0;
    bit             hold_valid = 1'b0;
    logic [2*DW+8:0] held;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Hand-derived twiddle bits for selected indices, forward transform:
    // {known, sel[3:0], swap, neg_re, neg_im}
    function automatic logic [7:0] hand_tw(input logic [5:0] n);
        case (n)
            6'd0:    hand_tw = {1'b1, 4'd0, 1'b0, 1'b0, 1'b1};
            6'd9:    hand_tw = {1'b1, 4'd1, 1'b0, 1'b0, 1'b1};
            6'd21:   hand_tw = {1'b1, 4'd6, 1'b1, 1'b0, 1'b1};
            6'd44:   hand_tw = {1'b1, 4'd4, 1'b1, 1'b1, 1'b1};
            6'd63:   hand_tw = {1'b1, 4'd1, 1'b1, 1'b0, 1'b0};
            default: hand_tw = 8'd0;
        endcase
    endfunction

    // Does the select/flag set reproduce W64^k (or its conjugate)?
    function automatic bit tw_ok(input logic [3:0] sel, input logic swap, input logic nre,
                                 input logic nim, input int k, input logic inv);
        real am, c, s, re, im, ak, er, ei;
        if (sel > 4'd8) return 1'b0;
        am = 2.0 * PI * real'(sel) / 64.0;
        c  = $cos(am);
        s  = $sin(am);
        re = swap ? s : c;
        im = swap ? c : s;
        if (nre) re = -re;
        if (nim) im = -im;
        ak = 2.0 * PI * real'(k) / 64.0;
        er = $cos(ak);
        ei = inv ? $sin(ak) : -$sin(ak);
        return ((re - er) < 1e-9) && ((er - re) < 1e-9) && ((im - ei) < 1e-9) && ((ei - im) < 1e-9);
    endfunction

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic sof, input logic inv);
        bit         done;
        logic [5:0] n;
        logic       iv;
        done            = 1'b0;
        bus.din_valid   = 1'b1;
        bus.din_real    = re;
        bus.din_imag    = im;
        bus.din_sof     = sof;
        bus.din_inverse = inv;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.din_ready) begin
                n = sof ? 6'd0 : n_model;
                iv = (n == 6'd0) ? inv : inv_model;
                if (sof && n_model != 6'd0) sync_arm = 1'b1;
                exp_q.push_back({re, im, sof, (n == 6'd63), n, iv});
                n_model   = n + 6'd1;
                inv_model = iv;
                done      = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got no din_ready expected acceptance");
        end
    endtask

    task automatic idle();
        bus.din_valid   = 1'b0;
        bus.din_sof     = 1'b0;
        bus.din_inverse = 1'b0;
    endtask

    // len samples, sof on the first; inverse given on sample 0, inv_mid afterwards
    task automatic frame(input int base, input logic inv, input logic inv_mid, input int len);
        for (int i = 0; i < len; i++) begin
            send(DW'(base + i * 53), DW'(base * 7 - i * 29), (i == 0), (i == 0) ? inv : inv_mid);
        end
    endtask

    task automatic flush();
        idle();
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL flush_timeout got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // downstream ready: held high or toggled at random each cycle
    initial begin
        bus.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor / scoreboard
    initial begin
        logic [W-1:0]    e;
        logic [2*DW+8:0] cur;
        logic [7:0]      h;
        int              k;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                sync_due   = 1'b0;
                sync_arm   = 1'b0;
                hold_valid = 1'b0;
            end else begin
                if (bus.sync_err || sync_due) check("sync_err", bus.sync_err, sync_due);
                sync_due = sync_arm;
                sync_arm = 1'b0;

                cur = {bus.dout_real, bus.dout_imag, bus.dout_sof, bus.dout_last,
                       bus.tw_sel, bus.tw_swap, bus.tw_neg_re, bus.tw_neg_im};
                if (hold_valid) check("stall_stable", cur, held);
                hold_valid = bus.dout_valid && !bus.dout_ready;
                held       = cur;

                if (bus.dout_valid && bus.dout_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output got valid beat expected none");
                    end else begin
                        e = exp_q.pop_front();
                        check("data_sof_last",
                              {bus.dout_real, bus.dout_imag, bus.dout_sof, bus.dout_last},
                              e[W-1:7]);
                        k = int'(e[6:4]) * int'(e[3:1]);
                        checks++;
                        if (!tw_ok(bus.tw_sel, bus.tw_swap, bus.tw_neg_re, bus.tw_neg_im, k, e[0])) begin
                            errors++;
                            $display("FAIL tw_value n=%0d k=%0d inv=%0d got sel=%0d swap=%0d neg_re=%0d neg_im=%0d expected W64^k",
                                     e[6:1], k, e[0], bus.tw_sel, bus.tw_swap, bus.tw_neg_re, bus.tw_neg_im);
                        end
                        h = hand_tw(e[6:1]);
                        if (h[7]) begin
                            check($sformatf("tw_hand_n%0d_inv%0d", e[6:1], e[0]),
                                  {bus.tw_sel, bus.tw_swap, bus.tw_neg_re, bus.tw_neg_im},
                                  {h[6:1], h[0] ^ e[0]});
                        end
                    end
                end
            end
        end
    end

    initial begin
        idle();
        bus.din_real = '0;
        bus.din_imag = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dout_valid", bus.dout_valid, 1'b0);
        check("reset_sync_err", bus.sync_err, 1'b0);
        check("reset_tw_sel", bus.tw_sel, 4'd0);
        check("reset_dout_real", bus.dout_real, '0);
        check("reset_din_ready", bus.din_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // forward and inverse frames at full rate
        rand_ready = 1'b0;
        frame(100, 1'b0, 1'b0, 64);
        frame(200, 1'b1, 1'b0, 64);
        flush();

        // same shapes under random backpressure, inverse flipped mid-frame
        rand_ready = 1'b1;
        frame(100, 1'b0, 1'b1, 64);
        frame(300, 1'b1, 1'b0, 64);
        flush();
        rand_ready = 1'b0;

        // early sof at sample 30 restarts the frame
        frame(400, 1'b0, 1'b0, 30);
        frame(450, 1'b0, 1'b0, 64);
        flush();

        // one-cycle reset in the middle of a frame
        frame(600, 1'b1, 1'b1, 20);
        rst_n = 1'b0;
        idle();
        exp_q.delete();
        n_model   = '0;
        inv_model = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_dout_valid", bus.dout_valid, 1'b0);
        check("midreset_sync_err", bus.sync_err, 1'b0);
        rst_n = 1'b1;
        frame(700, 1'b0, 1'b0, 64);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
